regs: RTL and testbench

- General-purpose register file for the RV32I pipeline: 32 x 32-bit architectural registers x0..x31.
- Two combinational read ports serve the decode stage, which forms op1/op2 for the execute stage.
- One synchronous write port consumes the execute stage's writeback triple (rd_addr, rd_data, rd_wen).
- A third read-only debug port lets the bench and simulation monitors inspect architectural state.

---
 rtl/regs.sv | 108 ++++++++++
 tb/tb_regs.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regs.sv
// ---------------------------------------------------------------------------
// regs: RV32I general-purpose register file (x0..x31).
//
// Two combinational read ports feed decode (rs1/rs2), one synchronous write
// port takes the execute-stage writeback triple, and a third combinational
// read port exposes architectural state to debug monitors.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-low reset
//   reg1_raddr_i   rs1 index         -> reg1_rdata_o  rs1 data
//   reg2_raddr_i   rs2 index         -> reg2_rdata_o  rs2 data
//   reg_waddr_i    rd index
//   reg_wdata_i    rd data
//   reg_wen_i      rd write enable
//   dbg_raddr_i    debug index       -> dbg_rdata_o   debug data (never bypassed)
//
// Optional feature (macro REGS_WRITE_BYPASS_EN):
//   defined   - a read port whose index matches an accepted write in the same
//               cycle returns the write data combinationally (0-cycle
//               write-to-read latency, closes the EX->ID RAW hazard).
//   undefined - read ports always return the stored contents; a write is
//               visible on the cycle after the edge that performs it.
// ---------------------------------------------------------------------------
module regs #(
  parameter int                   REG_NUM   = 32,
  parameter int                   REG_WIDTH = 32,
  parameter logic [REG_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           reg1_raddr_i,
  input  logic [4:0]           reg2_raddr_i,
  output logic [REG_WIDTH-1:0] reg1_rdata_o,
  output logic [REG_WIDTH-1:0] reg2_rdata_o,
  input  logic [4:0]           reg_waddr_i,
  input  logic [REG_WIDTH-1:0] reg_wdata_i,
  input  logic                 reg_wen_i,
  input  logic [4:0]           dbg_raddr_i,
  output logic [REG_WIDTH-1:0] dbg_rdata_o
);

`ifdef REGS_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // x0 has no storage; it is decoded as constant zero on every read port.
  logic [REG_WIDTH-1:0] regs_q [1:REG_NUM-1];
  logic [REG_WIDTH-1:0] regs_d [1:REG_NUM-1];

  // A write takes effect only when enabled, out of reset, and aimed at a
  // stored register. This same qualifier gates the bypass so that x0 writes
  // and writes during reset can never leak onto a read port.
  logic wr_fire;
  assign wr_fire = rst && reg_wen_i && (reg_waddr_i != 5'd0) &&
                   (int'(reg_waddr_i) < REG_NUM);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[reg_waddr_i] = reg_wdata_i;
    end
  end

  // Reset has priority, so a write presented on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero while in reset or for index 0 / unpopulated indices,
  // so outputs are defined even before the first reset edge completes.
  always_comb begin
    reg1_rdata_o = '0;
    if (rst && (reg1_raddr_i != 5'd0) && (int'(reg1_raddr_i) < REG_NUM)) begin
      reg1_rdata_o = regs_q[reg1_raddr_i];
    end
    if (BYPASS && wr_fire && (reg_waddr_i == reg1_raddr_i)) begin
      reg1_rdata_o = reg_wdata_i;
    end
  end

  always_comb begin
    reg2_rdata_o = '0;
    if (rst && (reg2_raddr_i != 5'd0) && (int'(reg2_raddr_i) < REG_NUM)) begin
      reg2_rdata_o = regs_q[reg2_raddr_i];
    end
    if (BYPASS && wr_fire && (reg_waddr_i == reg2_raddr_i)) begin
      reg2_rdata_o = reg_wdata_i;
    end
  end

  // The debug port shows committed architectural state only.
  always_comb begin
    dbg_rdata_o = '0;
    if (rst && (dbg_raddr_i != 5'd0) && (int'(dbg_raddr_i) < REG_NUM)) begin
      dbg_rdata_o = regs_q[dbg_raddr_i];
    end
  end

endmodule

// File: tb/tb_regs.sv
// ---------------------------------------------------------------------------
// tb_regs: self-checking bench for regs.
// A table of per-cycle vectors (inputs plus the outputs expected during that
// cycle) covers reset, basic access, x0, read-during-write, wen low and reset
// during a write; a randomized phase checks against a small reference model.
// Expected outputs are queued when a cycle is driven and popped at the
// falling edge, where the combinational outputs are sampled.
// ---------------------------------------------------------------------------
module tb_regs;

`ifdef REGS_WRITE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  // clock / reset block
  logic        clk;
  logic        rst;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, dbg_raddr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_wen_i;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, dbg_rdata_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  regs dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_rdata_o (reg2_rdata_o),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wen_i    (reg_wen_i),
    .dbg_raddr_i  (dbg_raddr_i),
    .dbg_rdata_o  (dbg_rdata_o)
  );

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  rad;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  // scoreboard
  logic [95:0] exp_q [$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model [32];

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] ad,
                              input logic [31:0] x1, input logic [31:0] x2,
                              input logic [31:0] xd);
    vec_t v;
    v.rst = r; v.wen = w; v.waddr = wa; v.wdata = wd;
    v.ra1 = a1; v.ra2 = a2; v.rad = ad;
    v.e1 = x1; v.e2 = x2; v.ed = xd;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs just after the rising edge
  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    rst          = v.rst;
    reg_wen_i    = v.wen;
    reg_waddr_i  = v.waddr;
    reg_wdata_i  = v.wdata;
    reg1_raddr_i = v.ra1;
    reg2_raddr_i = v.ra2;
    dbg_raddr_i  = v.rad;
    exp_q.push_back({v.e1, v.e2, v.ed});
  endtask

  task automatic sample(input string tag);
    logic [95:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".rd1"}, reg1_rdata_o, e[95:64]);
      cmp({tag, ".rd2"}, reg2_rdata_o, e[63:32]);
      cmp({tag, ".dbg"}, dbg_rdata_o,  e[31:0]);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] bx;
    rst = 1'b0; reg_wen_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    reg1_raddr_i = '0; reg2_raddr_i = '0; dbg_raddr_i = '0;

    //                rst wen wa  wdata         ra1 ra2 rad  e1 e2 ed
    vecs[0]  = mk(0, 0, 5'd0,  32'h0,        5, 5, 5,  0, 0, 0);
    vecs[1]  = mk(1, 1, 5'd5,  32'hDEAD_BEEF, 5, 0, 5,  BP ? 32'hDEAD_BEEF : 32'h0, 0, 0);
    vecs[2]  = mk(1, 0, 5'd0,  32'h0,        5, 5, 5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[3]  = mk(0, 0, 5'd0,  32'h0,        5, 5, 5,  0, 0, 0);
    vecs[4]  = mk(1, 0, 5'd0,  32'h0,        5, 5, 5,  0, 0, 0);
    vecs[5]  = mk(1, 1, 5'd1,  32'h10,       1, 31, 1, BP ? 32'h10 : 32'h0, 0, 0);
    vecs[6]  = mk(1, 1, 5'd31, 32'hFFFF_FFFF, 1, 31, 31, 32'h10, BP ? 32'hFFFF_FFFF : 32'h0, 0);
    vecs[7]  = mk(1, 0, 5'd0,  32'h0,        1, 31, 1, 32'h10, 32'hFFFF_FFFF, 32'h10);
    vecs[8]  = mk(1, 0, 5'd0,  32'h0,        31, 1, 31, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF);
    vecs[9]  = mk(1, 1, 5'd0,  32'h1234_5678, 0, 0, 0,  0, 0, 0);
    vecs[10] = mk(1, 0, 5'd0,  32'h0,        0, 0, 0,  0, 0, 0);
    vecs[11] = mk(1, 1, 5'd7,  32'hAAAA_0000, 7, 7, 7,  BP ? 32'hAAAA_0000 : 32'h0,
                  BP ? 32'hAAAA_0000 : 32'h0, 0);
    vecs[12] = mk(1, 1, 5'd7,  32'h5555_1111, 7, 7, 7,  BP ? 32'h5555_1111 : 32'hAAAA_0000,
                  BP ? 32'h5555_1111 : 32'hAAAA_0000, 32'hAAAA_0000);
    vecs[13] = mk(1, 0, 5'd0,  32'h0,        7, 7, 7,  32'h5555_1111, 32'h5555_1111, 32'h5555_1111);
    vecs[14] = mk(1, 0, 5'd3,  32'hCAFE_F00D, 3, 3, 3,  0, 0, 0);
    vecs[15] = mk(1, 0, 5'd0,  32'h0,        3, 3, 3,  0, 0, 0);
    vecs[16] = mk(0, 1, 5'd9,  32'h99,       9, 9, 9,  0, 0, 0);
    vecs[17] = mk(1, 0, 5'd0,  32'h0,        9, 7, 1,  0, 0, 0);
    vecs[18] = mk(1, 1, 5'd9,  32'h99,       9, 9, 9,  BP ? 32'h99 : 32'h0, BP ? 32'h99 : 32'h0, 0);
    vecs[19] = mk(1, 0, 5'd0,  32'h0,        9, 9, 9,  32'h99, 32'h99, 32'h99);
    vecs[20] = mk(1, 1, 5'd12, 32'h0C0C_0C0C, 12, 13, 12, BP ? 32'h0C0C_0C0C : 32'h0, 0, 0);
    vecs[21] = mk(1, 0, 5'd0,  32'h0,        12, 13, 12, 32'h0C0C_0C0C, 0, 32'h0C0C_0C0C);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      sample($sformatf("vec%0d", i));
    end

    // Randomized phase against a reference model, starting from a reset.
    drive(mk(0, 1, 5'd4, 32'h4444_4444, 4, 4, 4, 0, 0, 0));
    sample("rand_rst");
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    for (int n = 0; n < 300; n++) begin
      v.rst   = ($urandom_range(0, 29) != 0);
      v.wen   = ($urandom_range(0, 3) != 0);
      v.waddr = 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.ra1   = ($urandom_range(0, 2) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      v.ra2   = ($urandom_range(0, 2) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      v.rad   = ($urandom_range(0, 2) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      bx      = v.wdata;
      v.e1 = (!v.rst || v.ra1 == 0) ? 32'h0 :
             (BP && v.wen && v.waddr != 0 && v.waddr == v.ra1) ? bx : model[v.ra1];
      v.e2 = (!v.rst || v.ra2 == 0) ? 32'h0 :
             (BP && v.wen && v.waddr != 0 && v.waddr == v.ra2) ? bx : model[v.ra2];
      v.ed = (!v.rst || v.rad == 0) ? 32'h0 : model[v.rad];
      if (!v.rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (v.wen && v.waddr != 0) begin
        model[v.waddr] = v.wdata;
      end
      drive(v);
      sample($sformatf("rand%0d", n));
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
